updown_sat_counter: RTL and testbench

Parametrised up/down counter, the successor to the 6-bit saturating down-counter. It adds:
- count-up as well as count-down
- programmable step size
- synchronous load
- saturate or wrap-around mode, selected at run time
- zero/max status flags and single-cycle overflow/underflow event pulses

It is used wherever the lab designs need a bounded event counter, for example attempt counters, credit counters and timers.

---
 rtl/updown_sat_counter.sv | 98 +++++++++
 tb/tb_updown_sat_counter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/updown_sat_counter.sv
// Parameterised up/down counter with programmable step, synchronous load,
// run-time saturate/wrap selection, zero/max flags and overflow/underflow pulses.
// Optional macro UPDOWN_EDGE_DETECT_EN: inc/dec act only on their 0->1 transitions.
module updown_sat_counter #(
  parameter int unsigned           WIDTH       = 6,
  parameter int unsigned           STEP_W      = 3,
  parameter logic [WIDTH-1:0]      RESET_VALUE = WIDTH'(60)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              inc,
  input  logic              dec,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_value,
  input  logic [STEP_W-1:0] step,
  input  logic              wrap_mode,
  output logic [WIDTH-1:0]  count,
  output logic              zero,
  output logic              max,
  output logic              underflow,
  output logic              overflow
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic             inc_req, dec_req;
  logic [WIDTH:0]   step_ext, sum, diff;
  logic [WIDTH-1:0] count_nxt;
  logic             ovf_nxt, unf_nxt;

`ifdef UPDOWN_EDGE_DETECT_EN
  logic inc_q, dec_q;

  // History tracks the raw levels every cycle, regardless of en or load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inc_q <= 1'b0;
      dec_q <= 1'b0;
    end else begin
      inc_q <= inc;
      dec_q <= dec;
    end
  end

  assign inc_req = inc & ~inc_q;
  assign dec_req = dec & ~dec_q;
`else
  assign inc_req = inc;
  assign dec_req = dec;
`endif

  // One extra bit holds the carry (sum) or borrow (diff) out of the count.
  assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign sum      = {1'b0, count} + step_ext;
  assign diff     = {1'b0, count} - step_ext;

  always_comb begin
    count_nxt = count;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    if (load) begin
      count_nxt = load_value;
    end else if (en && (inc_req ^ dec_req)) begin
      if (inc_req) begin
        if (!sum[WIDTH]) begin
          count_nxt = sum[WIDTH-1:0];
        end else begin
          count_nxt = wrap_mode ? sum[WIDTH-1:0] : MAX_VAL;
          ovf_nxt   = 1'b1;
        end
      end else begin
        if (!diff[WIDTH]) begin
          count_nxt = diff[WIDTH-1:0];
        end else begin
          count_nxt = wrap_mode ? diff[WIDTH-1:0] : '0;
          unf_nxt   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= RESET_VALUE;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_nxt;
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
    end
  end

  assign zero = (count == '0);
  assign max  = (count == MAX_VAL);

endmodule

// File: tb/tb_updown_sat_counter.sv
// Directed bench for updown_sat_counter (WIDTH=6, STEP_W=3, RESET_VALUE=60).
// Expectations for held requests differ when UPDOWN_EDGE_DETECT_EN is defined.
module tb_updown_sat_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, inc, dec, load, wrap_mode;
  logic [5:0] load_value;
  logic [2:0] step;
  logic [5:0] count;
  logic       zero, max, underflow, overflow;

  int n_cmp = 0;
  int n_err = 0;

`ifdef UPDOWN_EDGE_DETECT_EN
  localparam int HOLD10_EXP = 59;
  localparam int BURST_EXP  = 29;
`else
  localparam int HOLD10_EXP = 50;
  localparam int BURST_EXP  = 28;
`endif

  updown_sat_counter #(.WIDTH(6), .STEP_W(3), .RESET_VALUE(6'd60)) dut (
    .clk(clk), .reset(reset), .en(en), .inc(inc), .dec(dec), .load(load),
    .load_value(load_value), .step(step), .wrap_mode(wrap_mode),
    .count(count), .zero(zero), .max(max),
    .underflow(underflow), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b1; inc = 1'b0; dec = 1'b0; load = 1'b0;
  endtask

  task automatic do_load(input logic [5:0] v);
    idle();
    load = 1'b1; load_value = v;
    tick();
    load = 1'b0;
  endtask

  task automatic pulses(input string tag, input int unf, input int ovf);
    check({tag, "_unf"}, int'(underflow), unf);
    check({tag, "_ovf"}, int'(overflow), ovf);
  endtask

  initial begin
    reset = 1'b0; wrap_mode = 1'b0; step = 3'd1; load_value = '0;
    idle();
    #12;
    check("rst_count", count, 60);
    check("rst_zero", zero, 0);
    check("rst_max", max, 0);
    pulses("rst", 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    check("post_rst_count", count, 60);

    // Load
    do_load(6'd5);
    check("load5", count, 5);

`ifndef UPDOWN_EDGE_DETECT_EN
    // Saturating down-count, level mode
    do_load(6'd60);
    dec = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      check("sat_dn_unf", underflow, 0);
    end
    check("sat_dn_count0", count, 0);
    check("sat_dn_zero", zero, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("sat_floor_count", count, 0);
      check("sat_floor_unf", underflow, 1);
    end
    dec = 1'b0;
    tick();
    check("sat_floor_release_unf", underflow, 0);
`endif

    // Saturate at floor with a single request (both modes)
    do_load(6'd2); step = 3'd3;
    dec = 1'b1; tick(); dec = 1'b0;
    check("sat_dn2_count", count, 0);
    check("sat_dn2_zero", zero, 1);
    pulses("sat_dn2", 1, 0);

    // Wrap and step
    wrap_mode = 1'b1; step = 3'd3;
    do_load(6'd1);
    dec = 1'b1; tick(); dec = 1'b0;
    check("wrap_dn_count", count, 62);
    pulses("wrap_dn", 1, 0);
    tick();
    check("wrap_dn_hold", count, 62);
    pulses("wrap_dn_after", 0, 0);
    do_load(6'd62);
    inc = 1'b1; tick(); inc = 1'b0;
    check("wrap_up_count", count, 1);
    pulses("wrap_up", 0, 1);
    tick();
    check("wrap_up_ovf_clear", overflow, 0);

    // Saturate at ceiling
    wrap_mode = 1'b0;
    do_load(6'd62);
    inc = 1'b1; tick(); inc = 1'b0;
    check("sat_up_count", count, 63);
    check("sat_up_max", max, 1);
    pulses("sat_up", 0, 1);
    tick();
    inc = 1'b1; tick(); inc = 1'b0;
    check("sat_up_at_max", count, 63);
    check("sat_up_at_max_ovf", overflow, 1);

    // Normal in-range steps
    do_load(6'd10);
    inc = 1'b1; tick(); inc = 1'b0;
    check("inc3", count, 13);
    pulses("inc3", 0, 0);
    tick();
    dec = 1'b1; tick(); dec = 1'b0;
    check("dec3", count, 10);
    tick();

    // step==0 holds without pulses
    step = 3'd0;
    dec = 1'b1; tick(); dec = 1'b0;
    check("step0_count", count, 10);
    pulses("step0", 0, 0);
    step = 3'd3;

    // Simultaneous and priority cases
    do_load(6'd20);
    inc = 1'b1; dec = 1'b1; tick(); inc = 1'b0; dec = 1'b0;
    check("cancel_count", count, 20);
    pulses("cancel", 0, 0);
    load = 1'b1; load_value = 6'd7; dec = 1'b1; tick(); idle();
    check("load_prio", count, 7);
    en = 1'b0; dec = 1'b1; tick(); idle();
    check("en0_hold", count, 7);
    pulses("en0", 0, 0);
    tick();

    // Held request for 10 cycles (one step only under edge detection)
    step = 3'd1;
    do_load(6'd60);
    dec = 1'b1;
    repeat (10) tick();
    dec = 1'b0;
    check("hold10", count, HOLD10_EXP);
    tick();

    // Separate one-cycle pulses each apply a step
    do_load(6'd59);
    for (int i = 0; i < 4; i++) begin
      dec = 1'b1; tick(); dec = 1'b0; tick();
    end
    check("pulses4", count, 55);

    // Async reset mid-burst, asserted between edges
    do_load(6'd30);
    dec = 1'b1; tick(); tick();
    check("burst_count", count, BURST_EXP);
    #2 reset = 1'b0;
    #1;
    check("async_rst_count", count, 60);
    check("async_rst_unf", underflow, 0);
    @(negedge clk);
    reset = 1'b1; idle();
    tick();

    // Async reset clears a live underflow pulse
    do_load(6'd0);
    dec = 1'b1; tick(); dec = 1'b0;
    check("pre_rst_unf", underflow, 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_unf2", underflow, 0);
    check("async_rst_count2", count, 60);
    @(negedge clk);
    reset = 1'b1;
    tick();

`ifdef UPDOWN_EDGE_DETECT_EN
    // History resets to 0, so a level held across reset release counts once
    dec = 1'b1; tick(); tick(); dec = 1'b0;
    check("edge_after_rst", count, 59);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
